video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/vtg_phase_counter.sv | 60 ++++++
 rtl/video_timing_gen.sv | 151 +++++++++++++++
 tb/tb_video_timing_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator: counter width,
// line/frame phase encoding and the colour-bar palette.
package video_timing_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Colour of bar idx, left (white) to right (black).
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = RGB_WHITE;
      3'd1:    rgb = RGB_YELLOW;
      3'd2:    rgb = RGB_CYAN;
      3'd3:    rgb = RGB_GREEN;
      3'd4:    rgb = RGB_MAGENTA;
      3'd5:    rgb = RGB_RED;
      3'd6:    rgb = RGB_BLUE;
      3'd7:    rgb = RGB_BLACK;
      default: rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vtg_phase_counter.sv
// Wrapping position counter (pixels within a line or lines within a frame)
// with phase decode ACTIVE -> FP -> SYNC -> BP and a carry-out that is high
// on the advancing cycle at the last position.
module vtg_phase_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 4,
  parameter int FP     = 1,
  parameter int SYNC   = 2,
  parameter int BP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output phase_t           phase,
  output logic             carry
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] A_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] F_END = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_r;
  phase_t           phase_s;

  // Position register: advance on inc, wrap from the last position to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (inc) begin
      if (cnt_r == LAST) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  // Phase decode of the current position.
  always_comb begin
    phase_s = PH_BP;
    if (cnt_r < A_END) begin
      phase_s = PH_ACTIVE;
    end else if (cnt_r < F_END) begin
      phase_s = PH_FP;
    end else if (cnt_r < S_END) begin
      phase_s = PH_SYNC;
    end else begin
      phase_s = PH_BP;
    end
  end

  assign cnt   = cnt_r;
  assign phase = phase_s;
  assign carry = inc && (cnt_r == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Raster video timing generator: hsync/vsync/data-enable, frame start pulse
// and pixel/line indices, all registered from the current (h,v) position.
// Optional colour-bar test pattern on o_rgb when TIMING_GEN_TEST_PATTERN_EN
// is defined; otherwise o_rgb is constant zero.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [15:0] o_h_cnt,
  output logic [15:0] o_v_cnt,
  output logic [23:0] o_rgb
);

  localparam logic POL = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  phase_t           h_phase_s;
  phase_t           v_phase_s;
  logic             h_carry_s;
  logic             v_carry_unused;

  logic             active_s;
  logic             hsync_s;
  logic             vsync_s;
  logic             first_s;

  logic             valid_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             frame_start_r;
  logic [15:0]      h_out_r;
  logic [15:0]      v_out_r;

  vtg_phase_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (en),
    .cnt   (h_cnt_s),
    .phase (h_phase_s),
    .carry (h_carry_s)
  );

  // Lines advance on the pixel wrap, so v wraps together with h.
  vtg_phase_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (h_carry_s),
    .cnt   (v_cnt_s),
    .phase (v_phase_s),
    .carry (v_carry_unused)
  );

  // Decode of the current position into next output values.
  always_comb begin
    active_s = (h_phase_s == PH_ACTIVE) && (v_phase_s == PH_ACTIVE);
    hsync_s  = (h_phase_s == PH_SYNC) ? POL : ~POL;
    vsync_s  = (v_phase_s == PH_SYNC) ? POL : ~POL;
    first_s  = (h_cnt_s == 16'd0) && (v_cnt_s == 16'd0);
  end

  // Output registers: follow the decode while enabled; while paused the
  // syncs and line index hold and the pixel-related outputs blank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r       <= 1'b0;
      hsync_r       <= ~POL;
      vsync_r       <= ~POL;
      frame_start_r <= 1'b0;
      h_out_r       <= 16'd0;
      v_out_r       <= 16'd0;
    end else if (en) begin
      valid_r       <= active_s;
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      frame_start_r <= first_s;
      h_out_r       <= active_s ? h_cnt_s : 16'd0;
      v_out_r       <= v_cnt_s;
    end else begin
      valid_r       <= 1'b0;
      frame_start_r <= 1'b0;
      h_out_r       <= 16'd0;
    end
  end

  assign valid       = valid_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign frame_start = frame_start_r;
  assign o_h_cnt     = h_out_r;
  assign o_v_cnt     = v_out_r;

`ifdef TIMING_GEN_TEST_PATTERN_EN
  // Bar width never drops to zero for very narrow test rasters.
  localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

  logic [15:0] bar_q_s;
  logic [2:0]  bar_idx_s;
  logic [23:0] rgb_s;
  logic [23:0] rgb_r;

  // Bar index from pixel column, clamped to the last bar.
  always_comb begin
    bar_q_s   = h_cnt_s / 16'(BAR_W);
    bar_idx_s = (bar_q_s > 16'd7) ? 3'd7 : bar_q_s[2:0];
    rgb_s     = active_s ? bar_rgb(bar_idx_s) : 24'h000000;
  end

  // Pattern register, aligned with valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_r <= 24'h000000;
    end else if (en) begin
      rgb_r <= rgb_s;
    end else begin
      rgb_r <= 24'h000000;
    end
  end

  assign o_rgb = rgb_r;
`else
  assign o_rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen. Three instances share stimulus:
// a small raster (sync active-high), the same raster with active-low sync,
// and a 16-pixel-wide raster for the colour bars. A pixel-index model
// predicts every output each cycle; directed checks pin the model.
module tb_video_timing_gen;

  typedef struct packed {
    logic        valid;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] hc;
    logic [15:0] vc;
    logic [23:0] rgb;
  } obs_t;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int pol;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic        valid_w [3];
  logic        hs_w    [3];
  logic        vs_w    [3];
  logic        fs_w    [3];
  logic [15:0] hc_w    [3];
  logic [15:0] vc_w    [3];
  logic [23:0] rgb_w   [3];
  obs_t        act     [3];

  int   nvec = 0;
  int   nfail = 0;
  int   pos [3];
  obs_t ex  [3];
  bit   armed = 1'b0;
  int   since_fs = 0;
  int   frame_len = 0;

  always #5 clk = ~clk;

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1))
  dut_a (.clk(clk), .rst_n(rst_n), .en(en), .valid(valid_w[0]), .hsync(hs_w[0]),
         .vsync(vs_w[0]), .frame_start(fs_w[0]), .o_h_cnt(hc_w[0]), .o_v_cnt(vc_w[0]),
         .o_rgb(rgb_w[0]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0))
  dut_b (.clk(clk), .rst_n(rst_n), .en(en), .valid(valid_w[1]), .hsync(hs_w[1]),
         .vsync(vs_w[1]), .frame_start(fs_w[1]), .o_h_cnt(hc_w[1]), .o_v_cnt(vc_w[1]),
         .o_rgb(rgb_w[1]));

  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1))
  dut_c (.clk(clk), .rst_n(rst_n), .en(en), .valid(valid_w[2]), .hsync(hs_w[2]),
         .vsync(vs_w[2]), .frame_start(fs_w[2]), .o_h_cnt(hc_w[2]), .o_v_cnt(vc_w[2]),
         .o_rgb(rgb_w[2]));

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      act[k] = {valid_w[k], hs_w[k], vs_w[k], fs_w[k], hc_w[k], vc_w[k], rgb_w[k]};
    end
  end

  function automatic cfg_t get_cfg(input int k);
    cfg_t c;
    case (k)
      0:       c = '{4, 1, 2, 1, 3, 1, 1, 1, 1};
      1:       c = '{4, 1, 2, 1, 3, 1, 1, 1, 0};
      default: c = '{16, 2, 2, 2, 2, 1, 1, 1, 1};
    endcase
    return c;
  endfunction

  function automatic int frame_total(input cfg_t c);
    return (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
  endfunction

  function automatic logic [23:0] bar_colour(input int i);
    logic [23:0] t [8];
    t = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return t[i];
  endfunction

  // Expected outputs for the pixel at linear frame index p.
  function automatic obs_t decode(input cfg_t c, input int p);
    obs_t o;
    int   ht, h, v, hs0, vs0;
    logic on, a;
    ht  = c.ha + c.hf + c.hs + c.hb;
    h   = p % ht;
    v   = p / ht;
    hs0 = c.ha + c.hf;
    vs0 = c.va + c.vf;
    on  = (c.pol != 0);
    a   = (h < c.ha) && (v < c.va);
    o.valid = a;
    o.hs    = (h >= hs0 && h < hs0 + c.hs) ? on : ~on;
    o.vs    = (v >= vs0 && v < vs0 + c.vs) ? on : ~on;
    o.fs    = (p == 0);
    o.hc    = a ? 16'(h) : 16'd0;
    o.vc    = 16'(v);
`ifdef TIMING_GEN_TEST_PATTERN_EN
    begin
      int bw, b;
      bw = (c.ha / 8 > 0) ? c.ha / 8 : 1;
      b  = h / bw;
      if (b > 7) b = 7;
      o.rgb = a ? bar_colour(b) : 24'h000000;
    end
`else
    o.rgb = 24'h000000;
`endif
    return o;
  endfunction

  function automatic obs_t idle(input cfg_t c);
    obs_t o;
    o = '0;
    o.hs = (c.pol != 0) ? 1'b0 : 1'b1;
    o.vs = o.hs;
    return o;
  endfunction

  function automatic obs_t paused(input obs_t prev);
    obs_t o;
    o = prev;
    o.valid = 1'b0;
    o.fs    = 1'b0;
    o.hc    = 16'd0;
    o.rgb   = 24'h000000;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nvec++;
    if (actual !== expected) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: one linear pixel index per instance, advanced on enabled edges.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        pos[k] <= 0;
        ex[k]  <= idle(get_cfg(k));
      end else if (en) begin
        ex[k]  <= decode(get_cfg(k), pos[k]);
        pos[k] <= (pos[k] + 1) % frame_total(get_cfg(k));
      end else begin
        ex[k]  <= paused(ex[k]);
      end
    end
    if (!rst_n) armed <= 1'b1;
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("dut%0d.valid", k), 32'(act[k].valid), 32'(ex[k].valid));
        check($sformatf("dut%0d.hsync", k), 32'(act[k].hs), 32'(ex[k].hs));
        check($sformatf("dut%0d.vsync", k), 32'(act[k].vs), 32'(ex[k].vs));
        check($sformatf("dut%0d.frame_start", k), 32'(act[k].fs), 32'(ex[k].fs));
        check($sformatf("dut%0d.h_cnt", k), 32'(act[k].hc), 32'(ex[k].hc));
        check($sformatf("dut%0d.v_cnt", k), 32'(act[k].vc), 32'(ex[k].vc));
        check($sformatf("dut%0d.rgb", k), 32'(act[k].rgb), 32'(ex[k].rgb));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    since_fs++;
    if (act[0].fs === 1'b1) begin
      frame_len = since_fs;
      since_fs  = 0;
    end
  endtask

  task automatic seek(input int target, input string name);
    int n;
    n = 0;
    while (pos[0] != target && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(n < 100), 32'd1);
  endtask

  function automatic logic [23:0] bars16(input int k);
`ifdef TIMING_GEN_TEST_PATTERN_EN
    if (k < 2) return 24'hFFFFFF;
    if (k < 4) return 24'hFFFF00;
    return 24'h000000;
`else
    return 24'h000000;
`endif
  endfunction

  initial begin
    int nv, nh, nvs, first_vs, n;
    rst_n = 1'b0;
    en    = 1'b1;
    tick();
    tick();
    // Reset state.
    check("rst.valid", 32'(act[0].valid), 32'd0);
    check("rst.hsync", 32'(act[0].hs), 32'd0);
    check("rst.vsync", 32'(act[0].vs), 32'd0);
    check("rst.fs", 32'(act[0].fs), 32'd0);
    check("rst.v_cnt", 32'(act[0].vc), 32'd0);
    check("rst.pol0_hsync", 32'(act[1].hs), 32'd1);
    check("rst.pol0_vsync", 32'(act[1].vs), 32'd1);
    check("rst.rgb", 32'(act[2].rgb), 32'd0);

    // First frame after release: 8-cycle lines, 6 lines, 48 cycles.
    rst_n = 1'b1;
    tick();
    check("rel.valid", 32'(act[0].valid), 32'd1);
    check("rel.fs", 32'(act[0].fs), 32'd1);
    check("rel.h_cnt", 32'(act[0].hc), 32'd0);
    check("rel.v_cnt", 32'(act[0].vc), 32'd0);
    nv = int'(act[0].valid);
    nh = int'(act[0].hs);
    nvs = int'(act[0].vs);
    first_vs = -1;
    for (int i = 1; i < 48; i++) begin
      tick();
      nv  += int'(act[0].valid);
      nh  += int'(act[0].hs);
      nvs += int'(act[0].vs);
      if (act[0].vs === 1'b1 && first_vs < 0) first_vs = i;
      if (i == 4) check("f1.hsync_h4", 32'(act[0].hs), 32'd0);
      if (i == 5) check("f1.hsync_h5", 32'(act[0].hs), 32'd1);
      if (i == 6) check("f1.pol0_hsync_h6", 32'(act[1].hs), 32'd0);
      if (i == 7) check("f1.hsync_h7", 32'(act[0].hs), 32'd0);
      if (i == 32) check("f1.pol0_vsync", 32'(act[1].vs), 32'd0);
      if (i == 47) check("f1.v_cnt_last", 32'(act[0].vc), 32'd5);
    end
    check("f1.valid_count", 32'(nv), 32'd12);
    check("f1.hsync_count", 32'(nh), 32'd12);
    check("f1.vsync_count", 32'(nvs), 32'd8);
    check("f1.vsync_first", 32'(first_vs), 32'd32);
    tick();
    check("f2.fs", 32'(act[0].fs), 32'd1);
    check("f2.v_cnt_wrap", 32'(act[0].vc), 32'd0);
    check("f1.frame_len", 32'(frame_len), 32'd48);

    // Pause for 3 cycles with position (h=2,v=1) pending.
    seek(10, "gap.seek");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap.valid", 32'(act[0].valid), 32'd0);
      check("gap.h_cnt", 32'(act[0].hc), 32'd0);
      check("gap.v_cnt", 32'(act[0].vc), 32'd1);
    end
    en = 1'b1;
    tick();
    check("gap.resume_valid", 32'(act[0].valid), 32'd1);
    check("gap.resume_h", 32'(act[0].hc), 32'd2);
    check("gap.resume_v", 32'(act[0].vc), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (act[0].fs !== 1'b1 && n < 200);
    check("gap.fs_seen", 32'(act[0].fs), 32'd1);
    check("gap.frame_len", 32'(frame_len), 32'd51);

    // Reset mid-frame with (h=3,v=2) pending.
    seek(19, "rst2.seek");
    rst_n = 1'b0;
    tick();
    check("rst2.valid", 32'(act[0].valid), 32'd0);
    check("rst2.h_cnt", 32'(act[0].hc), 32'd0);
    check("rst2.v_cnt", 32'(act[0].vc), 32'd0);
    check("rst2.hsync", 32'(act[0].hs), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst2.valid_rel", 32'(act[0].valid), 32'd1);
    check("rst2.h_rel", 32'(act[0].hc), 32'd0);
    check("rst2.v_rel", 32'(act[0].vc), 32'd0);
    check("rst2.fs_rel", 32'(act[0].fs), 32'd1);

    // Colour bars on the 16-pixel raster, tick k shows pixel h=k of line 0.
    check("bars.h0", 32'(act[2].rgb), 32'(bars16(0)));
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1 || k == 2 || k == 3 || k == 14 || k == 15)
        check($sformatf("bars.h%0d", k), 32'(act[2].rgb), 32'(bars16(k)));
      if (k == 16) check("bars.blank", 32'(act[2].rgb), 32'd0);
    end

    // Mixed enable pattern across several frames, checked by the model.
    for (int i = 0; i < 200; i++) begin
      en = (i % 7 == 3) ? 1'b0 : 1'b1;
      tick();
    end
    en = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
